pulse_selector_gen: RTL and testbench

PULSE_SELECTOR_GEN -- requirements
Module: pulse_selector_gen

---
 rtl/pulse_selector_gen.sv | 102 ++++++++++
 tb/tb_pulse_selector_gen.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pulse_selector_gen.sv
// rtl/pulse_selector_gen.sv - period tick generator with debounced, tick-committed state selector
module pulse_selector_gen #(
    parameter int DIV        = 25_000_000,
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       EN,
    input  logic [2:0] SW,
    output logic       PULSE,
    output logic [2:0] state_selector,
    output logic       sel_changed,
    output logic       sel_invalid
);

    localparam int CW = $clog2(DIV);
    localparam int DW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
    localparam logic [DW-1:0] DCNT_MAX = DW'(DEB_CYCLES - 1);
    localparam logic [2:0]    SEL_MAX  = 3'd5;

    logic [CW-1:0] r_cnt;
    logic          r_pulse;
    logic [2:0]    r_s1;
    logic [2:0]    r_s2;
    logic [2:0]    r_cand;
    logic [DW-1:0] r_dcnt;
    logic [2:0]    r_stable;
    logic [2:0]    r_state_sel;
    logic          r_sel_changed;
    logic          r_sel_invalid;

    logic          w_cnt_wrap;

    assign w_cnt_wrap = (r_cnt == CNT_MAX);

    // Divider: a tick already high still completes its cycle when EN drops.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else if (EN) begin
            if (w_cnt_wrap) begin
                r_cnt   <= '0;
                r_pulse <= 1'b1;
            end else begin
                r_cnt   <= r_cnt + 1'b1;
                r_pulse <= 1'b0;
            end
        end else begin
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end
    end

    // Synchronizer and debouncer; invalid codes 6/7 flag but never reach r_stable.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_s1          <= '0;
            r_s2          <= '0;
            r_cand        <= '0;
            r_dcnt        <= '0;
            r_stable      <= '0;
            r_sel_invalid <= 1'b0;
        end else begin
            r_s1 <= SW;
            r_s2 <= r_s1;
            if (r_s2 != r_cand) begin
                r_cand <= r_s2;
                r_dcnt <= '0;
                if (r_s2 <= SEL_MAX) begin
                    r_sel_invalid <= 1'b0;
                end
            end else if (r_dcnt != DCNT_MAX) begin
                r_dcnt <= r_dcnt + 1'b1;
            end else if (r_cand <= SEL_MAX) begin
                r_stable <= r_cand;
            end else begin
                r_sel_invalid <= 1'b1;
            end
        end
    end

    // Commit on the edge that ends a tick cycle, so downstream PULSE edges see a settled value.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state_sel   <= '0;
            r_sel_changed <= 1'b0;
        end else if (r_pulse) begin
            r_state_sel   <= r_stable;
            r_sel_changed <= (r_stable != r_state_sel);
        end else begin
            r_sel_changed <= 1'b0;
        end
    end

    assign PULSE          = r_pulse;
    assign state_selector = r_state_sel;
    assign sel_changed    = r_sel_changed;
    assign sel_invalid    = r_sel_invalid;

endmodule

// File: tb/tb_pulse_selector_gen.sv
// tb/tb_pulse_selector_gen.sv - directed and random checks of pulse_selector_gen against a history-based model
module tb_pulse_selector_gen;

    localparam int DIV = 4;
    localparam int DEB = 3;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       EN = 1'b0;
    logic [2:0] SW = 3'd0;
    logic       PULSE;
    logic [2:0] state_selector;
    logic       sel_changed;
    logic       sel_invalid;

    pulse_selector_gen #(.DIV(DIV), .DEB_CYCLES(DEB)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .EN             (EN),
        .SW             (SW),
        .PULSE          (PULSE),
        .state_selector (state_selector),
        .sel_changed    (sel_changed),
        .sel_invalid    (sel_invalid)
    );

    always #5 CLK = ~CLK;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state: edges since reset, SW sample history, run length of EN-high edges.
    int hist[$];
    int n_edge;
    int run_len;
    int m_pulse, m_ss, m_chg, m_inv, m_stable;

    function automatic int samp(int m);
        return (m < 1) ? 0 : hist[m-1];
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rst, input bit en, input int sw);
        int v;
        bit all_eq;
        if (rst) begin
            hist.delete();
            n_edge = 0; run_len = 0;
            m_pulse = 0; m_ss = 0; m_chg = 0; m_inv = 0; m_stable = 0;
            return;
        end
        n_edge++;
        hist.push_back(sw);
        if (m_pulse == 1) begin
            m_chg = (m_stable != m_ss) ? 1 : 0;
            m_ss  = m_stable;
        end else begin
            m_chg = 0;
        end
        // A value is accepted once DEB+1 consecutive synchronized samples agree.
        v = samp(n_edge - 2);
        all_eq = 1;
        for (int k = n_edge - DEB - 2; k <= n_edge - 2; k++)
            if (samp(k) != v) all_eq = 0;
        if (all_eq) begin
            if (v <= 5) m_stable = v;
            else        m_inv = 1;
        end else if (samp(n_edge - 2) != samp(n_edge - 3) && samp(n_edge - 2) <= 5) begin
            m_inv = 0;
        end
        if (en) begin
            run_len++;
            m_pulse = (run_len % DIV == 0) ? 1 : 0;
        end else begin
            run_len = 0;
            m_pulse = 0;
        end
    endtask

    task automatic check_all();
        chk("pulse", int'(PULSE), m_pulse);
        chk("state_selector", int'(state_selector), m_ss);
        chk("sel_changed", int'(sel_changed), m_chg);
        chk("sel_invalid", int'(sel_invalid), m_inv);
        chk("stable", int'(dut.r_stable), m_stable);
    endtask

    task automatic step(input bit rst, input bit en, input int sw);
        RESET = rst;
        EN    = en;
        SW    = sw[2:0];
        @(posedge CLK);
        model_edge(rst, en, sw);
        @(negedge CLK);
        check_all();
    endtask

    int pulses;
    int len;
    bit ren, rrst;
    int rsw;

    initial begin
        @(negedge CLK);
        step(1, 0, 0);
        step(1, 0, 0);
        chk("reset_pulse", int'(PULSE), 0);
        chk("reset_sel", int'(state_selector), 0);

        // Idle: ticks at edges 4, 8, 12, 16, 20 only.
        pulses = 0;
        for (int i = 1; i <= 20; i++) begin
            step(0, 1, 0);
            chk("idle_tick_pos", int'(PULSE), (i % 4 == 0) ? 1 : 0);
            pulses += int'(PULSE);
        end
        chk("idle_tick_count", pulses, 5);

        // Clean change to 3.
        for (int i = 1; i <= 12; i++) begin
            step(0, 1, 3);
            if (i == 6) chk("stable_at_edge6", int'(dut.r_stable), 3);
        end
        chk("sel_3", int'(state_selector), 3);

        // Glitches from a fresh reset: stable must never pass through 5.
        step(1, 1, 0);
        step(0, 1, 3); step(0, 1, 5); step(0, 1, 3); step(0, 1, 5);
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 3);
            chk("no_glitch_5", int'(dut.r_stable == 3'd5), 0);
        end

        // Invalid code held, then a valid one.
        for (int i = 0; i < 12; i++) step(0, 1, 7);
        chk("inv_high", int'(sel_invalid), 1);
        chk("inv_keeps_sel", int'(state_selector), 3);
        for (int i = 0; i < 14; i++) step(0, 1, 2);
        chk("inv_cleared", int'(sel_invalid), 0);
        chk("sel_2", int'(state_selector), 2);

        // EN drop mid-period, debounce continues meanwhile.
        step(0, 1, 4); step(0, 1, 4);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 4);
            chk("en_low_no_tick", int'(PULSE), 0);
        end
        for (int i = 1; i <= 4; i++) begin
            step(0, 1, 4);
            chk("en_resume_tick", int'(PULSE), (i == 4) ? 1 : 0);
        end
        step(0, 1, 4);
        chk("en_resume_commit", int'(state_selector), 4);

        // Reset during a tick cycle with the debouncer counting.
        step(0, 1, 1);
        for (int i = 0; i < 20 && PULSE !== 1'b1; i++) step(0, 1, 1);
        chk("found_tick", int'(PULSE), 1);
        step(1, 1, 1);
        chk("rst_pulse", int'(PULSE), 0);
        chk("rst_sel", int'(state_selector), 0);
        chk("rst_chg", int'(sel_changed), 0);
        chk("rst_inv", int'(sel_invalid), 0);
        chk("rst_cnt", int'(dut.r_cnt), 0);
        for (int i = 0; i < 8; i++) step(0, 1, 1);

        // Random held values of random length, occasional EN drops and resets.
        for (int i = 0; i < 150; i++) begin
            rsw  = int'($urandom_range(7));
            len  = int'($urandom_range(1, 7));
            ren  = ($urandom_range(9) != 0);
            rrst = ($urandom_range(49) == 0);
            for (int j = 0; j < len; j++) step(rrst && j == 0, ren, rsw);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
